// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit: default widths, the
// default reset PC and the {pc, inst} entry type carried from fetch to decode.
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam int          INST_W_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // One fetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [INST_W_DEF-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
// Two-entry ordered FIFO of {pc, inst} between the instruction memory and
// decode. Entry 0 is always the head, so the head is read straight from a
// register with no pointer mux.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drop every entry this cycle (push is ignored)
//   push, push_pc/inst  append an entry at the tail
//   pop                 remove the head entry
//   count               number of entries held, 0..2
//   head_valid          count != 0
//   head_pc, head_inst  contents of the head entry
// ---------------------------------------------------------------------------
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INST_W = INST_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [INST_W-1:0] push_inst,
    input  logic              pop,
    output logic [1:0]        count,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_pc,
    output logic [INST_W-1:0] head_inst
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    entry_t     ent_q [2];
    entry_t     ent_d [2];
    entry_t     wr_ent;
    logic [1:0] count_q, count_d;
    logic [1:0] wr_slot;
    logic       pop_ok, push_ok;

    assign wr_ent  = '{pc: push_pc, inst: push_inst};
    // Guards keep the FIFO consistent even if a caller misbehaves.
    assign pop_ok  = pop && (count_q != 2'd0);
    assign push_ok = push && ((count_q != 2'd2) || pop_ok);
    // Tail slot after any pop in the same cycle has shifted entry 1 down.
    assign wr_slot = count_q - {1'b0, pop_ok};

    always_comb begin
        ent_d   = ent_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (pop_ok) begin
                ent_d[0] = ent_q[1];
            end
            if (push_ok) begin
                ent_d[wr_slot[0]] = wr_ent;
            end
            count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < 2; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != 2'd0);
    assign head_pc    = ent_q[0].pc;
    assign head_inst  = ent_q[0].inst;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Sequential instruction fetch with redirect. The PC is issued to a memory
// with one cycle of read latency; returning words are parked in a 2-entry
// buffer whose head drives decode, so no output depends on imem_rdata.
// Issue is throttled so buffered + in-flight words never exceed two,
// which lets a stall of any length complete without losing a fetch.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   redirect_valid, redirect_pc  replace the fetch PC (flushes everything)
//   imem_en, imem_addr           fetch request (word address)
//   imem_rdata                   instruction, one cycle after imem_en
//   out_valid, out_ready         handshake towards decode
//   out_pc, out_pc4, out_inst    delivered instruction and its PC / PC+4
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INST_W   = INST_W_DEF,
    parameter int                IMEM_AW  = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INST_W-1:0]  imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc4,
    output logic [INST_W-1:0]  out_inst
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
    logic              infl_q, infl_d;

    logic [1:0]        count;
    logic              head_valid;
    logic [ADDR_W-1:0] head_pc;
    logic [INST_W-1:0] head_inst;
    logic              pop, push, issue;
    logic [2:0]        occ;
    logic              unused_bits;

    // Redirect targets are word aligned; the low bits are dropped.
    assign unused_bits = &{1'b0, redirect_pc[1:0]};

    assign pop = head_valid & out_ready;
    // Slots that will be occupied after this edge if nothing new is issued.
    // pop implies count >= 1, so this never underflows.
    assign occ   = {1'b0, count} + {2'b00, infl_q} - {2'b00, pop};
    assign issue = !rst && !redirect_valid && (occ < 3'd2);

    assign imem_en   = issue;
    assign imem_addr = pc_q[IMEM_AW+1:2];
    // A word returning for a redirected-away PC is simply not pushed.
    assign push      = infl_q && !redirect_valid;

    always_comb begin
        pc_d      = pc_q;
        infl_d    = 1'b0;
        infl_pc_d = infl_pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
        end else if (issue) begin
            pc_d      = pc_q + ADDR_W'(4);
            infl_d    = 1'b1;
            infl_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
        end else begin
            pc_q      <= pc_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
        end
    end

    fetch_buffer #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_pc    (infl_pc_q),
        .push_inst  (imem_rdata),
        .pop        (pop),
        .count      (count),
        .head_valid (head_valid),
        .head_pc    (head_pc),
        .head_inst  (head_inst)
    );

    // Payload is forced to zero whenever nothing is offered, so decode never
    // sees leftovers from a flushed entry.
    assign out_valid = head_valid;
    assign out_pc    = head_valid ? head_pc : '0;
    assign out_pc4   = head_valid ? head_pc + ADDR_W'(4) : '0;
    assign out_inst  = head_valid ? head_inst : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed scenarios followed by a randomized run. The reference model is
// the architectural stream: after reset or a redirect to T, decode must see
// T, T+4, T+8 ... in order with inst = mem[pc], and memory must be asked for
// the same sequence of word addresses.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic [31:0] out_inst;

    int          tests     = 0;
    int          failed    = 0;
    int          delivered = 0;
    logic [31:0] exp_pc    = 32'h0;
    logic [31:0] exp_issue = 32'h0;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_pc4        (out_pc4),
        .out_inst       (out_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [9:0] wa);
        return (32'h9E37_79B9 * ({22'd0, wa} + 32'd1)) ^ 32'hA5A5_0000;
    endfunction

    // Instruction memory: one-cycle registered read.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= inst_of(imem_addr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference model step, evaluated once per cycle before the edge.
    task automatic observe();
        if (rst) begin
            chk("rst_no_issue", {63'd0, imem_en}, 64'd0);
            exp_pc    = 32'h0;
            exp_issue = 32'h0;
        end else begin
            if (out_valid && out_ready) begin
                chk("xfer_pc", {32'd0, out_pc}, {32'd0, exp_pc});
                chk("xfer_pc4", {32'd0, out_pc4}, {32'd0, exp_pc + 32'd4});
                chk("xfer_inst", {32'd0, out_inst}, {32'd0, inst_of(exp_pc[11:2])});
                $display("[TB] xfer pc=%08h inst=%08h", out_pc, out_inst);
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (redirect_valid) begin
                chk("redir_no_issue", {63'd0, imem_en}, 64'd0);
                exp_pc    = {redirect_pc[31:2], 2'b00};
                exp_issue = {redirect_pc[31:2], 2'b00};
            end else if (imem_en) begin
                chk("issue_addr", {54'd0, imem_addr}, {54'd0, exp_issue[11:2]});
                exp_issue = exp_issue + 32'd4;
            end
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
        rst            = r;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic fin();
        observe();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;

        // Reset
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        fin(); fin(); fin();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_pc", {32'd0, out_pc}, 64'd0);
        chk("rst_pc4", {32'd0, out_pc4}, 64'd0);
        chk("rst_inst", {32'd0, out_inst}, 64'd0);
        chk("rst_addr", {54'd0, imem_addr}, 64'd0);
        fin();

        // Reset release and back-to-back stream
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk("a_issue_en", {63'd0, imem_en}, 64'd1);
        chk("a_issue_addr", {54'd0, imem_addr}, 64'd0);
        fin();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk("a_c1_valid", {63'd0, out_valid}, 64'd0);
        fin();
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            chk("a_stream_valid", {63'd0, out_valid}, 64'd1);
            chk("a_stream_pc", {32'd0, out_pc}, 64'(4 * k));
            fin();
        end

        // Five-cycle stall
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            chk("b_stall_en", {63'd0, imem_en}, 64'd0);
            chk("b_stall_valid", {63'd0, out_valid}, 64'd1);
            chk("b_stall_pc", {32'd0, out_pc}, {32'd0, exp_pc});
            fin();
        end
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            chk("b_resume_valid", {63'd0, out_valid}, 64'd1);
            fin();
        end

        // Redirect to 0x103 with a full buffer
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            fin();
        end
        drive(1'b0, 1'b0, 1'b1, 32'h103);
        fin();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk("c_valid_after", {63'd0, out_valid}, 64'd0);
        chk("c_issue_en", {63'd0, imem_en}, 64'd1);
        chk("c_issue_addr", {54'd0, imem_addr}, 64'h40);
        fin();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk("c_valid_c2", {63'd0, out_valid}, 64'd0);
        fin();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk("c_first_valid", {63'd0, out_valid}, 64'd1);
        chk("c_first_pc", {32'd0, out_pc}, 64'h100);
        fin();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            fin();
        end

        // Redirect coincident with a pop
        drive(1'b0, 1'b1, 1'b1, 32'h200);
        chk("d_valid_at_redir", {63'd0, out_valid}, 64'd1);
        fin();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk("d_valid_after", {63'd0, out_valid}, 64'd0);
        fin();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            fin();
        end

        // PC wrap at the top of the address space
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        fin();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk("e_issue_top", {54'd0, imem_addr}, 64'h3FF);
        fin();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk("e_issue_wrap_en", {63'd0, imem_en}, 64'd1);
        chk("e_issue_wrap", {54'd0, imem_addr}, 64'd0);
        fin();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk("e_top_pc", {32'd0, out_pc}, 64'hFFFF_FFFC);
        chk("e_top_pc4", {32'd0, out_pc4}, 64'd0);
        fin();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk("e_wrapped_pc", {32'd0, out_pc}, 64'd0);
        fin();

        // Reset with a full buffer, then reset while streaming
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            fin();
        end
        drive(1'b1, 1'b0, 1'b1, 32'h500);
        fin();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk("f_valid_after_rst", {63'd0, out_valid}, 64'd0);
        chk("f_refetch_en", {63'd0, imem_en}, 64'd1);
        chk("f_refetch_addr", {54'd0, imem_addr}, 64'd0);
        fin();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        fin();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk("f_first_pc", {32'd0, out_pc}, 64'd0);
        fin();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        fin();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk("f2_valid_after_rst", {63'd0, out_valid}, 64'd0);
        fin();

        // Randomized run against the stream model
        d0 = delivered;
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 70),
                  ($urandom_range(0, 99) < 5), $urandom);
            fin();
        end
        chk("g_liveness", {63'd0, ((delivered - d0) >= 100)}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
